calc_controller: RTL and testbench

CALC_CONTROLLER -- requirements
Module: calc_controller

---
 rtl/calc_controller.sv | 191 +++++++++++++++++++
 tb/tb_calc_controller.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_controller.sv
// Four-function calculator front end: debounced buttons drive a small sequencer
// that collects two signed operands, hands them to a shared ALU and holds the answer.
module calc_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int ALU_TIMEOUT     = 1024
) (
    input  logic        CLK100MHZ,
    input  logic        RST,
    input  logic [15:0] SW,
    input  logic        BTNU,
    input  logic        BTND,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic        BTNC,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic        alu_done,
    input  logic [32:0] alu_result,
    output logic [32:0] result,
    output logic [1:0]  disp_sel,
    output logic        busy,
    output logic        error
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TO_W = $clog2(ALU_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_OPERAND_B = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT      = 3'd3,
        S_RESULT    = 3'd4,
        S_ERROR     = 3'd5
    } state_t;

    state_t            r_state;
    logic [4:0]        r_sync1;
    logic [4:0]        r_sync2;
    logic [4:0]        r_level;
    logic [4:0]        r_press;
    logic [DB_W-1:0]   r_db_cnt [5];
    logic [TO_W-1:0]   r_wait_cnt;

    logic [4:0]        w_btn_raw;
    logic              w_op_press;
    logic              w_c_press;
    logic              w_any_press;
    logic [1:0]        w_win_op;

    // Bit order doubles as priority: index 0 (U) wins over everything above it.
    assign w_btn_raw = {BTNC, BTNR, BTNL, BTND, BTNU};

    // Synchronise each button, debounce it and emit a one-cycle pulse on an accepted press.
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            r_sync1 <= 5'b00000;
            r_sync2 <= 5'b00000;
            r_level <= 5'b00000;
            r_press <= 5'b00000;
            for (int i = 0; i < 5; i++) begin
                r_db_cnt[i] <= DB_W'(0);
            end
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 5; i++) begin
                r_press[i] <= 1'b0;
                if (r_sync2[i] == r_level[i]) begin
                    r_db_cnt[i] <= DB_W'(0);
                end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_level[i]  <= r_sync2[i];
                    r_db_cnt[i] <= DB_W'(0);
                    r_press[i]  <= r_sync2[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // Pick the single highest-priority press for this cycle.
    always_comb begin
        w_op_press  = 1'b0;
        w_c_press   = 1'b0;
        w_win_op    = 2'b00;
        w_any_press = |r_press;
        if (r_press[0]) begin
            w_op_press = 1'b1;
            w_win_op   = 2'b00;
        end else if (r_press[1]) begin
            w_op_press = 1'b1;
            w_win_op   = 2'b01;
        end else if (r_press[2]) begin
            w_op_press = 1'b1;
            w_win_op   = 2'b10;
        end else if (r_press[3]) begin
            w_op_press = 1'b1;
            w_win_op   = 2'b11;
        end else if (r_press[4]) begin
            w_c_press = 1'b1;
        end else begin
            w_op_press = 1'b0;
        end
    end

    // Operation sequencer; every output is a register updated alongside the state.
    always_ff @(posedge CLK100MHZ or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_wait_cnt <= TO_W'(0);
            alu_start  <= 1'b0;
            alu_op     <= 2'b00;
            alu_a      <= 16'h0000;
            alu_b      <= 16'h0000;
            result     <= 33'h0_0000_0000;
            disp_sel   <= 2'b00;
            busy       <= 1'b0;
            error      <= 1'b0;
        end else begin
            alu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_op_press) begin
                        alu_a   <= SW;
                        alu_op  <= w_win_op;
                        r_state <= S_OPERAND_B;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_OPERAND_B: begin
                    if (w_op_press) begin
                        alu_op <= w_win_op;
                    end else if (w_c_press) begin
                        // Divide by zero is refused here so the ALU never sees it.
                        if ((alu_op == 2'b11) && (SW == 16'h0000)) begin
                            error    <= 1'b1;
                            disp_sel <= 2'b10;
                            r_state  <= S_ERROR;
                        end else begin
                            alu_b     <= SW;
                            alu_start <= 1'b1;
                            busy      <= 1'b1;
                            disp_sel  <= 2'b01;
                            r_state   <= S_ISSUE;
                        end
                    end else begin
                        r_state <= S_OPERAND_B;
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= TO_W'(0);
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (alu_done) begin
                        result  <= alu_result;
                        busy    <= 1'b0;
                        r_state <= S_RESULT;
                    end else if (r_wait_cnt == TO_W'(ALU_TIMEOUT - 1)) begin
                        busy     <= 1'b0;
                        error    <= 1'b1;
                        disp_sel <= 2'b10;
                        r_state  <= S_ERROR;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
                    end
                end
                S_RESULT, S_ERROR: begin
                    if (w_any_press) begin
                        error    <= 1'b0;
                        disp_sel <= 2'b00;
                        r_state  <= S_IDLE;
                    end else begin
                        r_state <= r_state;
                    end
                end
                default: begin
                    busy     <= 1'b0;
                    error    <= 1'b0;
                    disp_sel <= 2'b00;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Randomised scoreboard bench for calc_controller with a behavioural ALU responder.
module tb_calc_controller;

    localparam int D = 4;
    localparam int T = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sw;
    logic        btnu, btnd, btnl, btnr, btnc;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [15:0] alu_a, alu_b;
    logic        alu_done;
    logic [32:0] alu_result;
    logic [32:0] result;
    logic [1:0]  disp_sel;
    logic        busy, error;

    calc_controller #(.DEBOUNCE_CYCLES(D), .ALU_TIMEOUT(T)) dut (
        .CLK100MHZ(clk), .RST(rst), .SW(sw),
        .BTNU(btnu), .BTND(btnd), .BTNL(btnl), .BTNR(btnr), .BTNC(btnc),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_done(alu_done), .alu_result(alu_result), .result(result),
        .disp_sel(disp_sel), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
    } start_t;

    start_t      exp_start_q[$];
    logic [32:0] exp_res_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          done_cyc = 0;
    int          start_count = 0;
    int          alu_delay = 3;
    bit          alu_withhold = 1'b0;
    int          inject_cnt = 0;
    logic [32:0] inject_val = 33'd0;
    logic [32:0] last_result = 33'd0;
    logic [15:0] last_b = 16'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Signed arithmetic straight from the operation definitions.
    function automatic logic [32:0] ref_alu(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        logic signed [32:0] x, y, r;
        x = {{17{a[15]}}, a};
        y = {{17{b[15]}}, b};
        case (op)
            2'b00: r = x + y;
            2'b01: r = x - y;
            2'b10: r = x * y;
            default: r = (y == 33'sd0) ? 33'sd0 : x / y;
        endcase
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            0: btnu = v;
            1: btnd = v;
            2: btnl = v;
            3: btnr = v;
            default: btnc = v;
        endcase
    endtask

    task automatic press(input int idx);
        set_btn(idx, 1'b1);
        tick(D + 6);
        set_btn(idx, 1'b0);
        tick(D + 6);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_start"}, alu_start, 0);
        check({tag, "_op"}, alu_op, 0);
        check({tag, "_a"}, alu_a, 0);
        check({tag, "_b"}, alu_b, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_disp"}, disp_sel, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_error"}, error, 0);
    endtask

    // ALU responder: answers each start after alu_delay cycles, or injects a stray strobe on request.
    initial begin
        int seen;
        seen = 0;
        alu_done = 1'b0;
        alu_result = 33'd0;
        forever begin
            @(negedge clk);
            if (inject_cnt != seen) begin
                seen = inject_cnt;
                alu_result = inject_val;
                done_cyc = cyc;
                alu_done = 1'b1;
                @(negedge clk);
                alu_done = 1'b0;
            end else if (alu_start === 1'b1 && !alu_withhold) begin
                repeat (alu_delay) @(negedge clk);
                alu_result = ref_alu(alu_op, alu_a, alu_b);
                done_cyc = cyc;
                alu_done = 1'b1;
                @(negedge clk);
                alu_done = 1'b0;
            end
        end
    end

    // Start monitor: every alu_start must match the next expected request.
    initial begin
        start_t e;
        forever begin
            @(negedge clk);
            if (alu_start === 1'b1) begin
                start_count++;
                if (exp_start_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_start actual=1 required=0");
                end else begin
                    e = exp_start_q.pop_front();
                    check("start_op", alu_op, e.op);
                    check("start_a", alu_a, e.a);
                    check("start_b", alu_b, e.b);
                    check("start_busy", busy, 1);
                end
            end
        end
    end

    // Result monitor: on entry to the result display, compare value and latency.
    initial begin
        logic prev_busy;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_busy && !busy && disp_sel == 2'b01 && !rst) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none", result);
                end else begin
                    check("result_val", result, exp_res_q.pop_front());
                    check("result_latency", cyc, done_cyc + 1);
                end
            end
            prev_busy = busy;
        end
    end

    task automatic finish_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b, input bit withhold);
        bit ok;
        start_t s;
        sw = b;
        alu_withhold = withhold;
        if (op == 2'b11 && b == 16'd0) begin
            press(4);
            check("div0_error", error, 1);
            check("div0_disp", disp_sel, 2'b10);
            check("div0_busy", busy, 0);
            check("div0_b_kept", alu_b, last_b);
        end else begin
            s.op = op; s.a = a; s.b = b;
            exp_start_q.push_back(s);
            if (!withhold) exp_res_q.push_back(ref_alu(op, a, b));
            press(4);
            ok = 1'b0;
            for (int i = 0; i < 60 && !ok; i++) begin
                if (!busy && disp_sel != 2'b00) ok = 1'b1;
                else tick(1);
            end
            check("settle", ok, 1);
            check("op_b", alu_b, b);
            if (withhold) begin
                check("to_error", error, 1);
                check("to_disp", disp_sel, 2'b10);
                check("to_result_kept", result, last_result);
                inject_val = 33'($urandom) ^ 33'h1_0000_0001;
                inject_cnt++;
                tick(4);
                check("late_done_result", result, last_result);
                check("late_done_error", error, 1);
            end else begin
                check("res_error", error, 0);
                check("res_disp", disp_sel, 2'b01);
                last_result = ref_alu(op, a, b);
            end
            last_b = b;
        end
        press($urandom % 5);
        check("back_disp", disp_sel, 2'b00);
        check("back_error", error, 0);
        check("back_busy", busy, 0);
        alu_withhold = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input int first_op, input int delay, input bit withhold);
        alu_delay = delay;
        sw = a;
        if (first_op >= 0) begin
            press(first_op);
            sw = 16'($urandom);
        end
        press(int'(op));
        check("opb_a", alu_a, a);
        check("opb_op", alu_op, op);
        check("opb_disp", disp_sel, 2'b00);
        finish_op(op, a, b, withhold);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(3);
        check_zero("rst");
        rst = 1'b0;
        tick(2);
        last_result = 33'd0;
        last_b = 16'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int sc;
        start_t s;
        rst = 1'b1;
        sw = 16'd0;
        btnu = 1'b0; btnd = 1'b0; btnl = 1'b0; btnr = 1'b0; btnc = 1'b0;
        tick(2);
        do_reset();

        // 7 + 5 with a three-cycle ALU
        run_op(2'b00, 16'd7, 16'd5, -1, 3, 1'b0);
        check("ex_result", result, 33'd12);
        // -9, switch to divide, divide by zero
        run_op(2'b11, 16'hFFF7, 16'd0, 2, 3, 1'b0);
        // withheld completion times out
        run_op(2'($urandom), 16'($urandom), 16'd3, -1, 3, 1'b1);

        // U and C together from idle, then a short glitch on D
        sw = 16'h1234;
        btnu = 1'b1; btnc = 1'b1;
        tick(D + 6);
        btnu = 1'b0; btnc = 1'b0;
        tick(D + 6);
        check("uc_op", alu_op, 2'b00);
        check("uc_a", alu_a, 16'h1234);
        btnd = 1'b1;
        tick(2);
        btnd = 1'b0;
        tick(D + 6);
        check("glitch_op", alu_op, 2'b00);
        alu_delay = 2;
        finish_op(2'b00, 16'h1234, 16'h0101, 1'b0);

        // reset during WAIT, then a stray completion
        alu_withhold = 1'b1;
        sw = 16'd40;
        press(2);
        sw = 16'd2;
        s.op = 2'b10; s.a = 16'd40; s.b = 16'd2;
        exp_start_q.push_back(s);
        press(4);
        check("wait_busy", busy, 1);
        rst = 1'b1;
        tick(2);
        check_zero("rstwait");
        rst = 1'b0;
        tick(1);
        inject_val = 33'd99;
        inject_cnt++;
        tick(4);
        check_zero("postrst");
        alu_withhold = 1'b0;
        last_result = 33'd0;
        last_b = 16'd0;

        // C held for 100 cycles gives one start
        alu_delay = 4;
        sw = 16'hFF00;
        press(1);
        sw = 16'd300;
        s.op = 2'b01; s.a = 16'hFF00; s.b = 16'd300;
        exp_start_q.push_back(s);
        exp_res_q.push_back(ref_alu(2'b01, 16'hFF00, 16'd300));
        sc = start_count;
        btnc = 1'b1;
        tick(100);
        btnc = 1'b0;
        tick(D + 6);
        check("hold_c_starts", start_count - sc, 1);
        check("hold_c_disp", disp_sel, 2'b01);
        last_result = ref_alu(2'b01, 16'hFF00, 16'd300);
        last_b = 16'd300;
        press(3);
        check("hold_c_back", disp_sel, 2'b00);

        // button held through reset release yields exactly one press
        sw = 16'h0042;
        btnu = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        last_result = 33'd0;
        last_b = 16'd0;
        tick(D + 6);
        btnu = 1'b0;
        tick(D + 6);
        check("held_rst_a", alu_a, 16'h0042);
        check("held_rst_op", alu_op, 2'b00);
        alu_delay = 1;
        finish_op(2'b00, 16'h0042, 16'hFFFE, 1'b0);

        // randomised operations
        for (int n = 0; n < 20; n++) begin
            logic [1:0]  op;
            logic [15:0] a, b;
            int          first;
            op = 2'($urandom);
            a = 16'($urandom);
            b = ($urandom % 5 == 0) ? 16'd0 : 16'($urandom);
            first = ($urandom % 3 == 0) ? int'($urandom % 4) : -1;
            run_op(op, a, b, first, 1 + int'($urandom % 6), ($urandom % 8 == 0));
        end

        tick(5);
        check("start_q_empty", exp_start_q.size(), 0);
        check("res_q_empty", exp_res_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
